fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction decoder. It walks a byte-addressed program counter, fetches 8-bit instructions from instruction memory over a req/ack handshake, and presents one instruction at a time to the decoder. It drives `force_nop` whenever no valid instruction is held. When the opcode is the load-next opcode `8'h80`, it fetches the following byte and presents it as an immediate alongside the opcode. It also accepts jump redirects from downstream and discards any in-flight fetch.

---
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Byte-wide instruction fetch with load-next immediate and redirect
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic                mem_ack,
    input  logic [7:0]          mem_rdata,
    output logic [7:0]          instr,
    output logic                force_nop,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic [7:0]          imm,
    output logic                imm_valid,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc
);

    localparam logic [7:0]          c_load_next = 8'h80;
    localparam logic [PC_WIDTH-1:0] c_pc_one    = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_REQ_IMM = 2'd1,
        S_OUT     = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t              r_state,       w_state;
    logic [PC_WIDTH-1:0] r_pc,          w_pc;
    logic                r_mem_req,     w_mem_req;
    logic [PC_WIDTH-1:0] r_mem_addr,    w_mem_addr;
    logic [7:0]          r_instr,       w_instr;
    logic [PC_WIDTH-1:0] r_instr_pc,    w_instr_pc;
    logic                r_instr_valid, w_instr_valid;
    logic [7:0]          r_imm,         w_imm;
    logic                r_imm_valid,   w_imm_valid;
    logic                r_force_nop;
    logic                w_ack;
    logic [PC_WIDTH-1:0] w_pc_inc;

    // An ack only counts against a request we are actually driving.
    assign w_ack    = mem_ack && r_mem_req;
    assign w_pc_inc = r_pc + c_pc_one;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_pc          <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instr       <= 8'h00;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_imm         <= 8'h00;
            r_imm_valid   <= 1'b0;
            r_force_nop   <= 1'b1;
        end else begin
            r_state       <= w_state;
            r_pc          <= w_pc;
            r_mem_req     <= w_mem_req;
            r_mem_addr    <= w_mem_addr;
            r_instr       <= w_instr;
            r_instr_pc    <= w_instr_pc;
            r_instr_valid <= w_instr_valid;
            r_imm         <= w_imm;
            r_imm_valid   <= w_imm_valid;
            r_force_nop   <= ~w_instr_valid;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_pc          = r_pc;
        w_mem_req     = r_mem_req;
        w_mem_addr    = r_mem_addr;
        w_instr       = r_instr;
        w_instr_pc    = r_instr_pc;
        w_instr_valid = r_instr_valid;
        w_imm         = r_imm;
        w_imm_valid   = r_imm_valid;

        case (r_state)
            S_REQ: begin
                // REQ is entered with the request low; it rises one cycle later.
                if (!r_mem_req) begin
                    w_mem_req  = 1'b1;
                    w_mem_addr = r_pc;
                end else if (w_ack) begin
                    w_instr    = mem_rdata;
                    w_instr_pc = r_pc;
                    w_pc       = w_pc_inc;
                    if (mem_rdata == c_load_next) begin
                        w_state    = S_REQ_IMM;
                        w_mem_addr = w_pc_inc;
                    end else begin
                        w_state       = S_OUT;
                        w_instr_valid = 1'b1;
                        w_mem_req     = 1'b0;
                    end
                end
            end
            S_REQ_IMM: begin
                if (w_ack) begin
                    w_imm         = mem_rdata;
                    w_pc          = w_pc_inc;
                    w_instr_valid = 1'b1;
                    w_imm_valid   = 1'b1;
                    w_mem_req     = 1'b0;
                    w_state       = S_OUT;
                end
            end
            S_OUT: begin
                if (!stall) begin
                    w_instr_valid = 1'b0;
                    w_imm_valid   = 1'b0;
                    w_state       = S_REQ;
                end
            end
            S_DRAIN: begin
                if (w_ack) begin
                    w_mem_req = 1'b0;
                    w_state   = S_REQ;
                end
            end
            default: w_state = S_REQ;
        endcase

        // A pending unacked request must be completed at its old address first.
        if (redirect) begin
            w_pc          = redirect_pc;
            w_instr       = r_instr;
            w_instr_pc    = r_instr_pc;
            w_imm         = r_imm;
            w_instr_valid = 1'b0;
            w_imm_valid   = 1'b0;
            if (r_mem_req && !mem_ack) begin
                w_state    = S_DRAIN;
                w_mem_req  = 1'b1;
                w_mem_addr = r_mem_addr;
            end else begin
                w_state   = S_REQ;
                w_mem_req = 1'b0;
            end
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign imm         = r_imm;
    assign imm_valid   = r_imm_valid;
    assign force_nop   = r_force_nop;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit with a wait-state memory model
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] instr;
    logic       force_nop;
    logic       instr_valid;
    logic [7:0] instr_pc;
    logic [7:0] imm;
    logic       imm_valid;
    logic       stall = 1'b0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = 8'h00;

    logic [7:0] mem    [256];
    int         mem_wt [256];
    int         rsp_cnt = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    fetch_unit #(.PC_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .force_nop   (force_nop),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc),
        .imm         (imm),
        .imm_valid   (imm_valid),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    // Memory: acks each request after mem_wt[addr] idle cycles.
    always @(negedge clk) begin
        if (!rst_n || !mem_req) begin
            mem_ack = 1'b0;
            rsp_cnt = 0;
        end else begin
            if (mem_ack) rsp_cnt = 0;
            if (rsp_cnt >= mem_wt[mem_addr]) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
            end else begin
                mem_ack = 1'b0;
                rsp_cnt++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'h00;
            mem_wt[i] = 0;
        end
    endtask

    task automatic do_reset();
        stall    = 1'b0;
        redirect = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [7:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] = 8'h12;
        rst_n  = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (force_nop !== 1'b1 || instr_valid !== 1'b0 || mem_req !== 1'b0 ||
            imm_valid !== 1'b0 || mem_addr !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_values: nop=%b valid=%b req=%b immv=%b addr=%h required 1 0 0 0 00",
                     force_nop, instr_valid, mem_req, imm_valid, mem_addr);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_first_req: req=%b addr=%h required 1 00", mem_req, mem_addr);
        end
    endtask

    task automatic test_straight();
        logic [7:0]  addrs[$];
        logic [15:0] seen[$];
        logic [7:0]  exp_addr[3];
        clear_mem();
        mem[0] = 8'h12;
        mem[1] = 8'h34;
        mem[2] = 8'h01;
        exp_addr[0] = 8'h00; exp_addr[1] = 8'h01; exp_addr[2] = 8'h02;
        do_reset();
        for (int c = 0; c < 30 && addrs.size() < 3; c++) begin
            tick();
            n_cmp++;
            if (force_nop !== !instr_valid) begin
                n_bad++;
                $display("FAIL straight_nop: nop=%b valid=%b", force_nop, instr_valid);
            end
            if (mem_req && mem_ack) addrs.push_back(mem_addr);
            if (instr_valid) seen.push_back({instr_pc, instr});
        end
        n_cmp++;
        if (addrs.size() != 3) begin
            n_bad++;
            $display("FAIL straight_addr_count: got %0d required 3", addrs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (addrs[i] !== exp_addr[i]) begin
                    n_bad++;
                    $display("FAIL straight_addr[%0d]: got %h required %h", i, addrs[i], exp_addr[i]);
                end
            end
        end
        n_cmp++;
        if (seen.size() != 2 || seen[0] !== 16'h0012 || seen[1] !== 16'h0134) begin
            n_bad++;
            $display("FAIL straight_instrs: count=%0d first=%h second=%h required 2 0012 0134",
                     seen.size(), (seen.size() > 0) ? seen[0] : 16'hxxxx,
                     (seen.size() > 1) ? seen[1] : 16'hxxxx);
        end
    endtask

    task automatic test_load_next();
        logic [7:0] addrs[$];
        bit         got_valid = 0;
        bit         wait_imm  = 0;
        clear_mem();
        mem[4] = 8'h80;
        mem[5] = 8'hAB;
        mem[6] = 8'h07;
        do_reset();
        tick();
        do_redirect(8'h04);
        for (int c = 0; c < 30 && addrs.size() < 3; c++) begin
            tick();
            if (wait_imm && !instr_valid) begin
                n_cmp++;
                if (force_nop !== 1'b1) begin
                    n_bad++;
                    $display("FAIL ln_nop_during_imm: nop=%b required 1", force_nop);
                end
            end
            if (mem_req && mem_ack) begin
                addrs.push_back(mem_addr);
                if (mem_addr == 8'h04) wait_imm = 1;
            end
            if (instr_valid && !got_valid) begin
                got_valid = 1;
                wait_imm  = 0;
                n_cmp++;
                if (instr !== 8'h80 || imm !== 8'hAB || imm_valid !== 1'b1 || instr_pc !== 8'h04) begin
                    n_bad++;
                    $display("FAIL ln_output: instr=%h imm=%h immv=%b pc=%h required 80 ab 1 04",
                             instr, imm, imm_valid, instr_pc);
                end
            end
        end
        n_cmp++;
        if (addrs.size() != 3 || addrs[0] !== 8'h04 || addrs[1] !== 8'h05 || addrs[2] !== 8'h06) begin
            n_bad++;
            $display("FAIL ln_addrs: count=%0d seq=%p required 04 05 06", addrs.size(), addrs);
        end
        n_cmp++;
        if (!got_valid) begin
            n_bad++;
            $display("FAIL ln_valid_seen: got 0 required 1");
        end
    endtask

    task automatic test_stall();
        logic [7:0] s_instr;
        logic [7:0] s_pc;
        int         c;
        clear_mem();
        mem[0] = 8'h5C;
        do_reset();
        for (c = 0; c < 20 && !instr_valid; c++) tick();
        n_cmp++;
        if (!instr_valid) begin
            n_bad++;
            $display("FAIL stall_valid_timeout: valid=%b required 1", instr_valid);
            return;
        end
        stall   = 1'b1;
        s_instr = instr;
        s_pc    = instr_pc;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_cmp++;
            if (instr_valid !== 1'b1 || instr !== 8'h5C || instr !== s_instr ||
                instr_pc !== s_pc || mem_req !== 1'b0 || force_nop !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc=%h req=%b nop=%b required 1 5c %h 0 0",
                         k, instr_valid, instr, instr_pc, mem_req, force_nop, s_pc);
            end
            if (k == 5) stall = 1'b0;
        end
        tick();
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_consume: valid=%b required 0", instr_valid);
        end
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin
            n_bad++;
            $display("FAIL stall_next_req: req=%b addr=%h required 1 01", mem_req, mem_addr);
        end
    endtask

    task automatic test_redirect_outstanding();
        int phase = 0;
        int c;
        clear_mem();
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[8'h40] = 8'h44;
        mem_wt[2] = 3;
        do_reset();
        for (c = 0; c < 40 && !(mem_req && mem_addr == 8'h02); c++) tick();
        n_cmp++;
        if (!(mem_req && mem_addr == 8'h02)) begin
            n_bad++;
            $display("FAIL redir_reach_addr2: req=%b addr=%h required 1 02", mem_req, mem_addr);
            return;
        end
        do_redirect(8'h40);
        for (c = 0; c < 20 && phase < 2; c++) begin
            n_cmp++;
            if (instr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL redir_no_valid: valid=%b required 0", instr_valid);
            end
            if (phase == 0) begin
                n_cmp++;
                if (mem_req !== 1'b1 || mem_addr !== 8'h02) begin
                    n_bad++;
                    $display("FAIL redir_hold_old: req=%b addr=%h required 1 02", mem_req, mem_addr);
                end
                if (mem_ack) phase = 1;
            end else if (mem_req) begin
                n_cmp++;
                if (mem_addr !== 8'h40) begin
                    n_bad++;
                    $display("FAIL redir_target: addr=%h required 40", mem_addr);
                end
                phase = 2;
            end
            tick();
        end
        n_cmp++;
        if (phase != 2) begin
            n_bad++;
            $display("FAIL redir_timeout: phase=%0d required 2", phase);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] addrs[$];
        bit         got_valid = 0;
        clear_mem();
        mem[8'hFF] = 8'h80;
        mem[0]     = 8'h5A;
        mem[1]     = 8'h02;
        do_reset();
        tick();
        do_redirect(8'hFF);
        for (int c = 0; c < 30 && addrs.size() < 3; c++) begin
            tick();
            if (mem_req && mem_ack) addrs.push_back(mem_addr);
            if (instr_valid && !got_valid) begin
                got_valid = 1;
                n_cmp++;
                if (instr !== 8'h80 || instr_pc !== 8'hFF || imm !== 8'h5A || imm_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL wrap_output: instr=%h pc=%h imm=%h immv=%b required 80 ff 5a 1",
                             instr, instr_pc, imm, imm_valid);
                end
            end
        end
        n_cmp++;
        if (addrs.size() != 3 || addrs[0] !== 8'hFF || addrs[1] !== 8'h00 || addrs[2] !== 8'h01) begin
            n_bad++;
            $display("FAIL wrap_addrs: count=%0d seq=%p required ff 00 01", addrs.size(), addrs);
        end
    endtask

    task automatic test_random();
        logic [7:0] m_pc = 8'h00;
        logic [7:0] nx;
        logic [7:0] exp_op;
        bit         prev_req = 0;
        bit         prev_ack = 0;
        logic [7:0] prev_addr = 8'h00;
        bit         n_stall;
        bit         n_redir;
        logic [7:0] n_tgt;
        int         idle = 0;
        int         consumed = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
            mem_wt[i] = $urandom_range(0, 2);
        end
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            n_cmp++;
            if (force_nop !== !instr_valid || (imm_valid && !instr_valid)) begin
                n_bad++;
                $display("FAIL rnd_flags: nop=%b valid=%b immv=%b", force_nop, instr_valid, imm_valid);
            end
            if (prev_req && !prev_ack) begin
                n_cmp++;
                if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
                    n_bad++;
                    $display("FAIL rnd_handshake: req=%b addr=%h required 1 %h", mem_req, mem_addr, prev_addr);
                end
            end
            exp_op = mem[m_pc];
            nx     = m_pc + 8'd1;
            if (instr_valid) begin
                idle = 0;
                n_cmp++;
                if (instr !== exp_op || instr_pc !== m_pc || imm_valid !== (exp_op == 8'h80) ||
                    (exp_op == 8'h80 && imm !== mem[nx])) begin
                    n_bad++;
                    $display("FAIL rnd_instr: instr=%h pc=%h immv=%b imm=%h required %h %h %b %h",
                             instr, instr_pc, imm_valid, imm, exp_op, m_pc, exp_op == 8'h80, mem[nx]);
                end
            end else begin
                idle++;
                if (idle > 30) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rnd_liveness: idle=%0d required <=30", idle);
                    break;
                end
            end
            n_stall = ($urandom_range(0, 9) < 3);
            n_redir = ($urandom_range(0, 19) == 0);
            n_tgt   = 8'($urandom);
            if (n_redir) begin
                m_pc = n_tgt;
                idle = 0;
            end else if (instr_valid && !n_stall) begin
                m_pc = (exp_op == 8'h80) ? m_pc + 8'd2 : nx;
                consumed++;
            end
            stall       = n_stall;
            redirect    = n_redir;
            redirect_pc = n_tgt;
            prev_req    = mem_req;
            prev_ack    = mem_ack;
            prev_addr   = mem_addr;
        end
        stall    = 1'b0;
        redirect = 1'b0;
        n_cmp++;
        if (consumed < 50) begin
            n_bad++;
            $display("FAIL rnd_progress: consumed=%0d required >=50", consumed);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b0 || force_nop !== 1'b1 || mem_addr !== 8'h00) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b req=%b nop=%b addr=%h required 0 0 1 00",
                     instr_valid, mem_req, force_nop, mem_addr);
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_straight();
        test_load_next();
        test_stall();
        test_redirect_outstanding();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
